logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal values are 2..64.
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1; reset is synchronous and active-low.
REQ-004 Port: in_valid, input, 1, an operand set is present on X, Y and s.
REQ-005 Port: in_ready, output, 1, the block can accept an operand set this cycle.
REQ-006 Port: X, input, WIDTH, operand X.
REQ-007 Port: Y, input, WIDTH, operand Y.
REQ-008 Port: s, input, 3, operation select.
REQ-009 Port: out_valid, output, 1, Z and the flags hold a valid result.
REQ-010 Port: out_ready, input, 1, the consumer accepts the result this cycle.
REQ-011 Port: Z, output, 2*WIDTH, the result.
REQ-012 Port: zero, output, 1, Z equals 0.
REQ-013 Port: parity, output, 1, XOR-reduction of Z[WIDTH-1:0].

Function
REQ-014 An input transfer occurs in a cycle where in_valid=1 and in_ready=1; an output transfer occurs in a cycle where out_valid=1 and out_ready=1.
REQ-015 Structure: two register stages, S1 (operands and s) and S2 (result and flags), each holding at most one entry with its own valid bit.
REQ-016 S2 accepts from S1 when S2 is empty or S2 is transferring out this cycle.
REQ-017 S1 accepts from the input when S1 is empty or S1 is moving to S2 this cycle.
REQ-018 in_ready is combinational: !s1_valid || (S1 moves to S2 this cycle); it has no dependency on in_valid.
REQ-019 Latency: a result is presented on out_valid on the 2nd rising edge after its input transfer, provided out_ready stays 1.
REQ-020 Throughput: with out_ready held at 1, one transfer per cycle, sustained.
REQ-021 With out_ready=0 the pipeline fills: two entries are accepted, then in_ready=0.
REQ-022 While out_valid=1 and out_ready=0, Z, zero and parity hold stable.
REQ-023 Results are delivered in input-transfer order; no entry is dropped or duplicated.
REQ-024 Operation s=000, AND: r = X & Y; Z = {WIDTH{r[WIDTH-1]}, r}.
REQ-025 Operation s=001, OR: r = X | Y; sign-extended as in REQ-024.
REQ-026 Operation s=010, NOT-pair: Z = {~X, ~Y}, unextended, with ~X in the upper half.
REQ-027 Operation s=011, XOR: r = X ^ Y; sign-extended.
REQ-028 Operation s=100, NAND; s=101, NOR; s=110, XNOR; each is bitwise on X and Y and sign-extended.
REQ-029 Operation s=111, PASS: Z = {WIDTH{X[WIDTH-1]}, X}.
REQ-030 zero and parity are computed from the same Z that is registered in S2.
REQ-031 Input transfer and output transfer in the same cycle with both stages full: both occur, and occupancy stays at 2.
REQ-032 X, Y and s are don't-care when in_valid=0; they have no effect on state.

Reset
REQ-033 When rst_n=0 at a rising edge: s1_valid=0, s2_valid=0, out_valid=0, Z=0, zero=0, parity=0.
REQ-034 While rst_n=0, in_ready=0 and any input transfer attempt is ignored.
REQ-035 in_ready=1 in the first cycle after rst_n rises.
REQ-036 Reset asserted mid-operation discards all in-flight entries; no result from before the reset appears afterwards.

Verification
REQ-037 WIDTH=8, out_ready=1: send s=000, X=F0, Y=3C -> two cycles later out_valid=1, Z=0030, zero=0, parity=0.
REQ-038 Back-to-back sends s=001 (F0,0C), s=010 (0F,AA), s=011 (AA,AA) -> results FFFC, F055, then 0000 with zero=1, on consecutive cycles.
REQ-039 out_ready=0, four sends attempted -> exactly two accepted, in_ready=0, Z stable; then release out_ready -> two results in order, in_ready returns to 1.
REQ-040 Both stages full, simultaneous input and output transfer every cycle for 10 cycles -> no loss, order preserved, occupancy stays at 2.
REQ-041 Assert reset with two entries in flight -> next cycle out_valid=0, Z=0; after release, a fresh send of s=111, X=80 -> Z=FF80, parity=1.
REQ-042 WIDTH=16 smoke test: s=100, X=FFFF, Y=FFFF -> Z=00000000, zero=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit: S1 registers the operands and select, S2 registers
// the sign-extended result together with its zero and parity flags.
module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    input  logic [2:0]           s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Z,
    output logic                 zero,
    output logic                 parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_x;
    logic [WIDTH-1:0]   s1_y;
    op_e                s1_op;
    logic               s2_valid;

    logic               in_fire;
    logic               out_fire;
    logic               s2_accept;
    logic               s1_move;
    logic [WIDTH-1:0]   r;
    logic [2*WIDTH-1:0] z_next;

    // Handshake: a transfer happens on any rising edge where valid and ready are
    // both high; ready never looks at valid, and in_ready is held low in reset.
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;
    assign s2_accept = !s2_valid || out_fire;
    assign s1_move   = s1_valid && s2_accept;
    assign in_ready  = rst_n && (!s1_valid || s1_move);
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        r      = '0;
        z_next = '0;
        case (s1_op)
            OP_AND:  r = s1_x & s1_y;
            OP_OR:   r = s1_x | s1_y;
            OP_XOR:  r = s1_x ^ s1_y;
            OP_NAND: r = ~(s1_x & s1_y);
            OP_NOR:  r = ~(s1_x | s1_y);
            OP_XNOR: r = ~(s1_x ^ s1_y);
            default: r = s1_x;
        endcase
        // NOT-pair fills both halves itself; every other op is sign-extended.
        if (s1_op == OP_NOT) begin
            z_next = {~s1_x, ~s1_y};
        end else begin
            z_next = {{WIDTH{r[WIDTH-1]}}, r};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_op    <= OP_AND;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_x     <= X;
                s1_y     <= Y;
                s1_op    <= op_e'(s);
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            Z        <= '0;
            zero     <= 1'b0;
            parity   <= 1'b0;
        end else begin
            if (s1_move) begin
                s2_valid <= 1'b1;
                Z        <= z_next;
                zero     <= (z_next == '0);
                parity   <= ^z_next[WIDTH-1:0];
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus randomized traffic, all results
// checked against a queue-based reference model of the operation table.
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        zero;
    logic        parity;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] x16;
    logic [15:0] y16;
    logic [2:0]  op16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] z16;
    logic        zero16;
    logic        parity16;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] held_z;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(x), .Y(y), .s(op), .out_valid(out_valid), .out_ready(out_ready),
        .Z(z), .zero(zero), .parity(parity)
    );

    logic_unit_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .X(x16), .Y(y16), .s(op16), .out_valid(out_valid16), .out_ready(out_ready16),
        .Z(z16), .zero(zero16), .parity(parity16)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: operation table from the operation definitions, sign extension by
    // signed assignment.
    function automatic logic [15:0] ref_z(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
        logic [7:0]         res;
        logic signed [15:0] ext;
        case (sel)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd3: res = a ^ b;
            3'd4: res = ~(a & b);
            3'd5: res = ~(a | b);
            3'd6: res = ~(a ^ b);
            default: res = a;
        endcase
        if (sel == 3'd2) return {~a, ~b};
        ext = $signed(res);
        return ext;
    endfunction

    // scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("hold_z", {16'h0, z}, {16'h0, held_z});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("sb_z", {16'h0, z}, {16'h0, e});
                    check("sb_zero", {31'h0, zero}, {31'h0, (e == 16'h0)});
                    check("sb_parity", {31'h0, parity}, {31'h0, 1'(($countones(e[7:0])) % 2)});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_z(x, y, op));
            stall_prev = out_valid && !out_ready;
            held_z = z;
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        int n = 0;
        in_valid = 1'b1;
        x = a;
        y = b;
        op = sel;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        logic stalled;
        rst_n = 1'b0;
        in_valid = 1'b1;
        x = 8'hA5;
        y = 8'h5A;
        op = 3'd0;
        out_ready = 1'b1;
        in_valid16 = 1'b0;
        x16 = '0;
        y16 = '0;
        op16 = '0;
        out_ready16 = 1'b1;

        // reset state, with an input transfer being attempted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_z", {16'h0, z}, 32'd0);
        check("rst_zero", {31'h0, zero}, 32'd0);
        check("rst_parity", {31'h0, parity}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("post_rst_no_out", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // single AND, latency of two edges
        send(8'hF0, 8'h3C, 3'd0);
        @(negedge clk);
        check("lat_not_early", {31'h0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'h0, out_valid}, 32'd1);
        check("and_z", {16'h0, z}, 32'h0030);
        check("and_zero", {31'h0, zero}, 32'd0);
        check("and_parity", {31'h0, parity}, 32'd0);
        @(posedge clk);
        #1;
        drain();

        // back-to-back OR, NOT-pair, XOR
        send(8'hF0, 8'h0C, 3'd1);
        send(8'h0F, 8'hAA, 3'd2);
        send(8'hAA, 8'hAA, 3'd3);
        @(negedge clk);
        check("b2b_valid2", {31'h0, out_valid}, 32'd1);
        check("b2b_z2", {16'h0, z}, 32'hF055);
        @(negedge clk);
        check("b2b_valid3", {31'h0, out_valid}, 32'd1);
        check("b2b_z3", {16'h0, z}, 32'h0000);
        check("b2b_zero3", {31'h0, zero}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // backpressure: four attempts, two accepted
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = 8'($urandom);
            y = 8'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, 32'd2);
        @(negedge clk);
        check("fill_in_ready", {31'h0, in_ready}, 32'd0);
        check("fill_out_valid", {31'h0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("release_in_ready", {31'h0, in_ready}, 32'd1);

        // both stages full, simultaneous in/out transfers for 10 cycles
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd4);
        send(8'h56, 8'h78, 3'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x = 8'($urandom);
            y = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            @(negedge clk);
            check("full_in_ready", {31'h0, in_ready}, 32'd1);
            check("full_out_valid", {31'h0, out_valid}, 32'd1);
            check("full_occupancy", exp_q.size(), 32'd2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // reset with two entries in flight
        out_ready = 1'b0;
        send(8'h11, 8'h22, 3'd6);
        send(8'h33, 8'h44, 3'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        check("midrst_out_valid", {31'h0, out_valid}, 32'd0);
        check("midrst_z", {16'h0, z}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(8'h80, 8'h5F, 3'd7);
        @(negedge clk);
        @(negedge clk);
        check("pass_valid", {31'h0, out_valid}, 32'd1);
        check("pass_z", {16'h0, z}, 32'hFF80);
        check("pass_parity", {31'h0, parity}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // randomized traffic with random backpressure, data held while stalled
        stalled = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x = 8'($urandom);
                y = 8'($urandom);
                op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            stalled = in_valid && !in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // WIDTH=16 smoke test: NAND of all-ones
        begin
            int n = 0;
            in_valid16 = 1'b1;
            x16 = 16'hFFFF;
            y16 = 16'hFFFF;
            op16 = 3'd4;
            @(negedge clk);
            @(posedge clk);
            #1 in_valid16 = 1'b0;
            @(negedge clk);
            while (!out_valid16 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("w16_valid", {31'h0, out_valid16}, 32'd1);
            check("w16_z", z16, 32'h0000_0000);
            check("w16_zero", {31'h0, zero16}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
